// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle ALU. Logic, add, shift and rotate ops complete in
//                one cycle. Signed MUL/DIV run bit-serially and return a
//                2*WIDTH HI/LO result through a start/busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_sub  = 5'b00100;
    localparam logic [4:0] c_op_shr  = 5'b00101;
    localparam logic [4:0] c_op_shra = 5'b00110;
    localparam logic [4:0] c_op_shl  = 5'b00111;
    localparam logic [4:0] c_op_ror  = 5'b01000;
    localparam logic [4:0] c_op_rol  = 5'b01001;
    localparam logic [4:0] c_op_and  = 5'b01010;
    localparam logic [4:0] c_op_or   = 5'b01011;
    localparam logic [4:0] c_op_mul  = 5'b01111;
    localparam logic [4:0] c_op_div  = 5'b10000;
    localparam logic [4:0] c_op_neg  = 5'b10001;
    localparam logic [4:0] c_op_not  = 5'b10010;

    localparam logic [SHW-1:0] c_cnt_last = SHW'(WIDTH - 1);
    localparam logic [SHW:0]   c_width    = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SHW-1:0]     r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;   // product sign (MUL) or quotient sign (DIV)
    logic               r_neg_hi;   // remainder sign: follows the dividend
    logic               r_div0;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_acc;      // product high half or partial remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier / dividend, shifts into result

    logic               w_muldiv;
    logic [SHW-1:0]     w_sh;
    logic [SHW:0]       w_sh_inv;
    logic [WIDTH-1:0]   w_single_res;
    logic               w_illegal;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_fix_hi;

    assign busy     = (r_state != S_IDLE);
    assign w_muldiv = (op == c_op_mul) || (op == c_op_div);
    assign w_sh     = b[SHW-1:0];
    // Complementary shift for rotates; a shift by WIDTH yields zero, so sh=0 returns a
    assign w_sh_inv = c_width - {1'b0, w_sh};
    assign w_mag_a  = a[WIDTH-1] ? (-a) : a;
    assign w_mag_b  = b[WIDTH-1] ? (-b) : b;

    // One shift-add step: add multiplicand when the multiplier LSB is set
    assign w_mul_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    // One restoring-division step: the borrow bit tells whether the divisor fits
    assign w_div_shift = {r_acc, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
    assign w_div_ge    = ~w_div_diff[WIDTH];

    assign w_prod   = {r_acc, r_lo};
    assign w_prod_s = r_neg_lo ? (-w_prod) : w_prod;

    // Single-cycle operation results and opcode legality
    always_comb begin
        w_single_res = '0;
        w_illegal    = 1'b0;
        case (op)
            c_op_add:  w_single_res = a + b;
            c_op_sub:  w_single_res = a - b;
            c_op_shr:  w_single_res = a >> w_sh;
            c_op_shra: w_single_res = $signed(a) >>> w_sh;
            c_op_shl:  w_single_res = a << w_sh;
            c_op_ror:  w_single_res = (a >> w_sh) | (a << w_sh_inv);
            c_op_rol:  w_single_res = (a << w_sh) | (a >> w_sh_inv);
            c_op_and:  w_single_res = a & b;
            c_op_or:   w_single_res = a | b;
            c_op_neg:  w_single_res = -a;
            c_op_not:  w_single_res = ~a;
            c_op_mul,
            c_op_div:  w_single_res = '0;
            default:   w_illegal    = 1'b1;
        endcase
    end

    // Sign correction applied in FIX for the multi-cycle ops
    always_comb begin
        w_fix_lo = w_prod_s[WIDTH-1:0];
        w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_lo = '1;
                w_fix_hi = r_a_orig;
            end else begin
                w_fix_lo = r_neg_lo ? (-r_lo)  : r_lo;
                w_fix_hi = r_neg_hi ? (-r_acc) : r_acc;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; divide by zero bypasses the iteration phase
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_muldiv) begin
                    if ((op == c_op_div) && (b == '0)) begin
                        w_next_state = S_FIX;
                    end else begin
                        w_next_state = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (r_cnt == c_cnt_last) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath, result and flag registers
    always_ff @(posedge clock) begin
        if (clear) begin
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_div0      <= 1'b0;
            r_a_orig    <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_lo        <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_muldiv) begin
                            r_is_div <= (op == c_op_div);
                            r_a_orig <= a;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_hi <= (op == c_op_div) && a[WIDTH-1];
                            r_div0   <= (op == c_op_div) && (b == '0);
                            // DIV shifts the dividend out; MUL shifts the multiplier out
                            r_lo     <= (op == c_op_div) ? w_mag_a : w_mag_b;
                            r_mcand  <= (op == c_op_div) ? w_mag_b : w_mag_a;
                        end else begin
                            result_lo   <= w_single_res;
                            result_hi   <= '0;
                            zero        <= (w_single_res == '0);
                            div_by_zero <= 1'b0;
                            illegal_op  <= w_illegal;
                            done        <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
                    end else begin
                        {r_acc, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    result_lo   <= w_fix_lo;
                    result_hi   <= w_fix_hi;
                    zero        <= (w_fix_lo == '0);
                    div_by_zero <= r_is_div && r_div0;
                    illegal_op  <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Scoreboard bench for seq_alu: directed cases plus random ops
//                checked against a signed-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;
    logic         illegal_op;

    seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         dz;
        logic         il;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: plain signed arithmetic and bit-at-a-time rotation
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int now);
        exp_t e;
        int sh;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] p;
        logic [W-1:0] v;
        sh  = int'(y[4:0]);
        sx  = 64'(signed'(x));
        sy  = 64'(signed'(y));
        e.lo = '0; e.hi = '0; e.dz = 1'b0; e.il = 1'b0; e.due = now + 1;
        case (o)
            5'd3:  e.lo = x + y;
            5'd4:  e.lo = x - y;
            5'd5:  e.lo = x >> sh;
            5'd6:  begin p = sx >>> sh; e.lo = p[W-1:0]; end
            5'd7:  e.lo = x << sh;
            5'd8:  begin v = x; for (int i = 0; i < sh; i++) v = {v[0], v[W-1:1]}; e.lo = v; end
            5'd9:  begin v = x; for (int i = 0; i < sh; i++) v = {v[W-2:0], v[W-1]}; e.lo = v; end
            5'd10: e.lo = x & y;
            5'd11: e.lo = x | y;
            5'd15: begin
                p = sx * sy;
                e.lo = p[W-1:0]; e.hi = p[63:32]; e.due = now + W + 2;
            end
            5'd16: begin
                if (y == '0) begin
                    e.lo = '1; e.hi = x; e.dz = 1'b1; e.due = now + 2;
                end else begin
                    p = sx / sy; e.lo = p[W-1:0];
                    p = sx % sy; e.hi = p[W-1:0];
                    e.due = now + W + 2;
                end
            end
            5'd17: e.lo = -x;
            5'd18: e.lo = ~x;
            default: e.il = 1'b1;
        endcase
        e.z = (e.lo == '0);
        return e;
    endfunction

    // Issue one operation at a negedge once the DUT is free; records its expectation
    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("issue_wait_busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = o; a = x; b = y;
        sbq.push_back(model(o, x, y, cyc));
        @(negedge clock);
        start = 1'b0;
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (!clear && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("result_lo",   64'(result_lo),   64'(e.lo));
                chk("result_hi",   64'(result_hi),   64'(e.hi));
                chk("zero",        64'(zero),        64'(e.z));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("illegal_op",  64'(illegal_op),  64'(e.il));
                chk("done_cycle",  64'(cyc),         64'(e.due));
                chk("busy_in_done", 64'(busy),       64'd0);
            end
        end
    end

    logic [4:0] ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                             5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [4:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n;
        clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy",   64'(busy),        64'd0);
        chk("rst_done",   64'(done),        64'd0);
        chk("rst_lo",     64'(result_lo),   64'd0);
        chk("rst_hi",     64'(result_hi),   64'd0);
        chk("rst_zero",   64'(zero),        64'd0);
        chk("rst_dbz",    64'(div_by_zero), 64'd0);
        chk("rst_ill",    64'(illegal_op),  64'd0);
        clear = 1'b0;
        @(negedge clock);

        issue(5'd3, 32'd7, 32'hFFFF_FFF9);
        chk("add_busy", 64'(busy), 64'd0);
        @(negedge clock);

        issue(5'd6, 32'h8000_0000, 32'd4);
        issue(5'd9, 32'h8000_0001, 32'd33);
        issue(5'd8, 32'h0000_0003, 32'd0);

        issue(5'd15, 32'hFFFF_FFFD, 32'd7);
        repeat (5) @(negedge clock);
        start = 1'b1; op = 5'd3; a = 32'd1; b = 32'd1;
        @(negedge clock);
        start = 1'b0;

        issue(5'd16, 32'hFFFF_FFEF, 32'd5);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd16, 32'd42, 32'd0);
        issue(5'd10, 32'h0000_F0F0, 32'h0000_FF00);

        // Abort a multiply with clear partway through
        issue(5'd15, 32'd1234, 32'd5678);
        repeat (9) @(negedge clock);
        clear = 1'b1;
        sbq.delete(sbq.size() - 1);
        @(negedge clock);
        clear = 1'b0;
        chk("abort_busy", 64'(busy),      64'd0);
        chk("abort_done", 64'(done),      64'd0);
        chk("abort_lo",   64'(result_lo), 64'd0);
        chk("abort_hi",   64'(result_hi), 64'd0);
        repeat (W + 5) @(negedge clock);

        issue(5'b11111, 32'd5, 32'd6);
        issue(5'd17, 32'd1, 32'd0);

        for (int i = 0; i < 80; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 12)];
            ra = rnd_operand();
            rb = rnd_operand();
            if (ro == 5'd16 && $urandom_range(0, 5) == 0) rb = '0;
            issue(ro, ra, rb);
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end

        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
